// File: rtl/busca_instrucao.sv
// Instruction fetch: PC register + 2-entry {pc, instr} buffer toward decode; fetched entry visible one edge later.
// Backpressure: out_valid/out_ready handshake; full buffer without dequeue stalls pc; redirect flushes and overrides all.
module busca_instrucao #(
  parameter int              BITS     = 32,
  parameter logic [BITS-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic [4:0]      imem_endr,
  input  logic [BITS-1:0] imem_dout,
  input  logic            redirect_valid,
  input  logic [BITS-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] out_instr,
  output logic [BITS-1:0] out_pc,
  output logic            desalinhado
);

  typedef enum logic {
    BUSCA  = 1'b0,
    PARADO = 1'b1
  } estado_t;

  estado_t         estado;
  estado_t         estado_prox;
  logic [BITS-1:0] pc;
  logic [BITS-1:0] pc_prox;
  logic            desal_prox;
  logic [BITS-1:0] fila_pc    [2];
  logic [BITS-1:0] fila_instr [2];
  logic [1:0]      count;
  logic            enq;
  logic            deq;
  logic            slot_enq;

  assign imem_endr = pc[6:2];
  assign out_valid = (count != 2'd0);
  assign out_pc    = out_valid ? fila_pc[0]    : '0;
  assign out_instr = out_valid ? fila_instr[0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado <= BUSCA;
    end else begin
      estado <= estado_prox;
    end
  end

  // Redirect wins over everything: the in-flight fetch and the head are both dropped.
  always_comb begin
    estado_prox = estado;
    pc_prox     = pc;
    desal_prox  = desalinhado;
    enq         = 1'b0;
    deq         = 1'b0;
    if (redirect_valid) begin
      pc_prox = redirect_pc;
      if (redirect_pc[1:0] == 2'b00) begin
        estado_prox = BUSCA;
        desal_prox  = 1'b0;
      end else begin
        estado_prox = PARADO;
        desal_prox  = 1'b1;
      end
    end else begin
      deq = out_valid && out_ready;
      if (estado == BUSCA && (count != 2'd2 || deq)) begin
        enq     = 1'b1;
        pc_prox = pc + BITS'(4);
      end
    end
  end

  // Slot the new entry lands in, after any same-cycle shift of the head.
  assign slot_enq = (count == 2'd2) || (count == 2'd1 && !deq);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc            <= RESET_PC;
      desalinhado   <= 1'b0;
      count         <= 2'd0;
      fila_pc[0]    <= '0;
      fila_pc[1]    <= '0;
      fila_instr[0] <= '0;
      fila_instr[1] <= '0;
    end else begin
      pc          <= pc_prox;
      desalinhado <= desal_prox;
      if (redirect_valid) begin
        count <= 2'd0;
      end else begin
        if (deq) begin
          fila_pc[0]    <= fila_pc[1];
          fila_instr[0] <= fila_instr[1];
        end
        if (enq) begin
          if (slot_enq) begin
            fila_pc[1]    <= pc;
            fila_instr[1] <= imem_dout;
          end else begin
            fila_pc[0]    <= pc;
            fila_instr[0] <= imem_dout;
          end
        end
        count <= count + {1'b0, enq} - {1'b0, deq};
      end
    end
  end

endmodule

// File: tb/tb_busca_instrucao.sv
// Bench for busca_instrucao: directed scenarios then random traffic against a queue-based reference model.
module tb_busca_instrucao;

  logic        clk;
  logic        reset_n;
  logic [4:0]  imem_endr;
  logic [31:0] imem_dout;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        desalinhado;

  logic [31:0] mem [32];
  assign imem_dout = mem[imem_endr];

  busca_instrucao #(.BITS(32), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_endr      (imem_endr),
    .imem_dout      (imem_dout),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .desalinhado    (desalinhado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_pc;
  logic        m_halt;
  logic        m_des;
  int          checks;
  int          errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc   = 32'h0000_0000;
    m_halt = 1'b0;
    m_des  = 1'b0;
  endtask

  task automatic model_step();
    if (redirect_valid) begin
      m_q.delete();
      m_pc   = redirect_pc;
      m_halt = (redirect_pc[1:0] != 2'b00);
      m_des  = m_halt;
    end else begin
      if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
      if (!m_halt && m_q.size() < 2) begin
        m_q.push_back('{pc: m_pc, instr: mem[m_pc[6:2]]});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, {31'b0, out_valid}, {31'b0, m_q.size() != 0});
    chk({tag, ".pc"}, out_pc, (m_q.size() != 0) ? m_q[0].pc : 32'h0);
    chk({tag, ".instr"}, out_instr, (m_q.size() != 0) ? m_q[0].instr : 32'h0);
    chk({tag, ".desal"}, {31'b0, desalinhado}, {31'b0, m_des});
    chk({tag, ".endr"}, {27'b0, imem_endr}, {27'b0, m_pc[6:2]});
  endtask

  // Called at a negedge: drive, clock, update model, check, return at the next negedge.
  task automatic tick(input string tag, input logic rv, input logic [31:0] rpc, input logic rdy);
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [31:0] rpc;
    checks = 0;
    errors = 0;
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;
    model_reset();
    #1;
    check_all("reset0");
    @(negedge clk);
    reset_n = 1'b1;

    // Streaming with decode always ready
    tick("stream0", 1'b0, 32'h0, 1'b1);
    chk("stream_first_pc", out_pc, 32'h0);
    chk("stream_first_instr", out_instr, mem[0]);
    tick("stream1", 1'b0, 32'h0, 1'b1);
    chk("stream_second_pc", out_pc, 32'h4);
    tick("stream2", 1'b0, 32'h0, 1'b1);
    chk("stream_third_instr", out_instr, mem[2]);

    // Stall: buffer fills, pc holds at 8, then drains in order
    do_reset("reset1");
    for (int i = 0; i < 4; i++) tick("stall", 1'b0, 32'h0, 1'b0);
    chk("stall_endr", {27'b0, imem_endr}, 32'd2);
    chk("stall_head", out_pc, 32'h0);
    for (int i = 0; i < 4; i++) tick("drain", 1'b0, 32'h0, 1'b1);

    // Redirect with a full buffer
    do_reset("reset2");
    tick("fill", 1'b0, 32'h0, 1'b0);
    tick("fill", 1'b0, 32'h0, 1'b0);
    tick("redir", 1'b1, 32'h24, 1'b1);
    chk("redir_flush", {31'b0, out_valid}, 32'd0);
    tick("redir_fetch", 1'b0, 32'h0, 1'b0);
    chk("redir_pc", out_pc, 32'h24);
    chk("redir_instr", out_instr, mem[9]);

    // Misaligned redirect halts until an aligned one
    tick("misal", 1'b1, 32'h1002, 1'b1);
    chk("misal_flag", {31'b0, desalinhado}, 32'd1);
    for (int i = 0; i < 3; i++) tick("halted", 1'b0, 32'h0, 1'b1);
    chk("halted_valid", {31'b0, out_valid}, 32'd0);
    tick("realign", 1'b1, 32'h0, 1'b1);
    chk("realign_flag", {31'b0, desalinhado}, 32'd0);
    tick("resume", 1'b0, 32'h0, 1'b1);
    chk("resume_pc", out_pc, 32'h0);

    // Word index wraps past 0x7C
    tick("wrap_set", 1'b1, 32'h7C, 1'b1);
    tick("wrap_f0", 1'b0, 32'h0, 1'b1);
    chk("wrap_endr", {27'b0, imem_endr}, 32'd0);
    tick("wrap_f1", 1'b0, 32'h0, 1'b1);
    chk("wrap_outpc", out_pc, 32'h80);
    chk("wrap_instr", out_instr, mem[0]);

    // Asynchronous reset with a full buffer
    for (int i = 0; i < 3; i++) tick("prefull", 1'b0, 32'h0, 1'b0);
    do_reset("async_rst");
    chk("async_valid", {31'b0, out_valid}, 32'd0);
    tick("post_rst", 1'b0, 32'h0, 1'b1);
    chk("post_rst_pc", out_pc, 32'h0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rpc = $urandom;
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
      if ($urandom_range(0, 1) == 0) rpc[31:7] = '0;
      tick("rand", ($urandom_range(0, 11) == 0), rpc, ($urandom_range(0, 2) != 0));
      if (i == 200) do_reset("rand_rst");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/busca_instrucao.md
BUSCA_INSTRUCAO -- requirements
Module: busca_instrucao

Interface
REQ-001 SHALL have parameter BITS, default 32, instruction and PC width.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port imem_endr, output, 5, word index to instruction memory, equal to pc[6:2].
REQ-006 SHALL have port imem_dout, input, BITS, instruction returned combinationally for imem_endr in the same cycle.
REQ-007 SHALL have port redirect_valid, input, 1, jump/branch redirect request from execute.
REQ-008 SHALL have port redirect_pc, input, BITS, redirect target byte address.
REQ-009 SHALL have port out_valid, input-side of decode: output, 1, buffer head holds a valid instruction.
REQ-010 SHALL have port out_ready, input, 1, decode accepts head this cycle.
REQ-011 SHALL have port out_instr, output, BITS, instruction at buffer head.
REQ-012 SHALL have port out_pc, output, BITS, byte PC of out_instr.
REQ-013 SHALL have port desalinhado, output, 1, sticky misaligned-redirect flag.

Function
REQ-014 SHALL hold a BITS-wide PC register and a 2-entry FIFO of {pc, instr} pairs with occupancy count 0..2.
REQ-015 SHALL implement a two-state FSM: BUSCA (fetching) and PARADO (halted on misalignment).
REQ-016 In BUSCA, without redirect, SHALL enqueue {pc, imem_dout} and advance pc by 4 when count<2 or a dequeue occurs the same cycle.
REQ-017 SHALL dequeue the head when out_valid and out_ready are both 1; out_valid = (count!=0).
REQ-018 Simultaneous enqueue and dequeue at count 2 SHALL leave count 2 with FIFO order preserved; at count 1 or 0 likewise keep count and order correct.
REQ-019 When count=2 and no dequeue, SHALL hold pc and buffer contents unchanged (stall).
REQ-020 redirect_valid SHALL take priority over enqueue and dequeue: buffer flushed (count 0) at the next edge, the current fetch discarded, head not consumed.
REQ-021 On redirect with redirect_pc[1:0]==0, SHALL load pc<=redirect_pc, stay/enter BUSCA, clear desalinhado.
REQ-022 On redirect with redirect_pc[1:0]!=0, SHALL load pc<=redirect_pc, enter PARADO, set desalinhado=1.
REQ-023 In PARADO, SHALL not enqueue or advance pc; only a subsequent aligned redirect returns to BUSCA.
REQ-024 PC SHALL wrap modulo 2^BITS on increment; imem_endr SHALL wrap modulo 32 words.
REQ-025 Latency: an instruction fetched at edge N SHALL appear on out_instr/out_pc with out_valid=1 after edge N when it is the head.
REQ-026 out_instr/out_pc SHALL hold stable while out_valid=1 and out_ready=0.

Reset
REQ-027 reset_n=0 SHALL immediately force pc=RESET_PC, count=0, FSM=BUSCA, out_valid=0, desalinhado=0, out_instr=0, out_pc=0.
REQ-028 Reset asserted mid-stall or mid-redirect SHALL discard all buffered entries; first fetch after release uses RESET_PC.

Verification
REQ-029 Reset release, out_ready=1, mem[0..2]=A,B,C -> out_valid from cycle 1, out_pc 0,4,8 with instr A,B,C one per cycle.
REQ-030 out_ready=0 for 4 cycles after reset -> count saturates at 2, pc stalls at 8, out_pc stays 0; release ready -> 0,4,8 in order, no loss or duplication.
REQ-031 Buffer full (pc 0,4 buffered), redirect_valid with redirect_pc=0x24 -> next cycle out_valid=0, then out_pc=0x24 with instr mem[9].
REQ-032 redirect_pc=0x1002 -> desalinhado=1, out_valid=0 indefinitely; then redirect_pc=0x0 -> desalinhado=0, fetch resumes at 0.
REQ-033 pc=0x7C, out_ready=1 -> next fetch pc=0x80, imem_endr=0 (wrap), out_pc=0x80.
REQ-034 reset_n pulsed low asynchronously between edges with count=2 -> out_valid=0 immediately, first out_pc after release = RESET_PC.
